// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned operands.
// All state advances on the falling edge of clk so results line up with the
// downstream flag register, which also captures on the falling edge.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one shift-add step per edge, WIDTH steps total
// DONE  | result just written; done pulses for this one cycle
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             carry_flag
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  // one spare bit so the add of two WIDTH-bit magnitudes never overflows
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             cf_q, cf_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw_res, fin_res;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // exactly its magnitude when read as unsigned.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // One shift-add step and the final signed fix-up of the full product.
  always_comb begin
    sum     = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    raw_res = {sum, mplr_q[WIDTH-1:1]};
    fin_res = neg_q ? (~raw_res + 1'b1) : raw_res;
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    sgn_d     = sgn_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    cf_d      = cf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a_mag;
          mplr_d  = b_mag;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          sgn_d   = is_signed;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = {1'b0, sum[WIDTH:1]};
        mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          prod_lo_d = fin_res[WIDTH-1:0];
          prod_hi_d = fin_res[2*WIDTH-1:WIDTH];
          zf_d      = (fin_res == '0);
          sf_d      = fin_res[2*WIDTH-1];
          cf_d      = sgn_q ? (fin_res[2*WIDTH-1:WIDTH] != {WIDTH{fin_res[WIDTH-1]}})
                            : (fin_res[2*WIDTH-1:WIDTH] != '0);
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, falling-edge clocked, async active-low clear.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      cf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      sgn_q     <= sgn_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      cf_q      <= cf_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign product_lo = prod_lo_q;
  assign product_hi = prod_hi_q;
  assign zero_flag  = zf_q;
  assign sign_flag  = sf_q;
  assign carry_flag = cf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a transaction model predicts results
// with plain arithmetic; a monitor checks every cycle on the rising edge.
module tb_seq_multiplier;
  localparam int W = 32;

  logic         clk = 1'b1;
  logic         rst;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] product_lo, product_hi;
  logic         zero_flag, sign_flag, carry_flag;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         zf;
    logic         sf;
    logic         cf;
  } res_t;

  res_t exp_q[$];
  res_t hold_exp = '0;
  int   m_rem = 0;
  int   n_done = 0;
  int   checks = 0;
  int   errors = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
    .busy(busy), .done(done), .product_lo(product_lo), .product_hi(product_hi),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [2*W-1:0] p;
    res_t r;
    if (s) p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
    else   p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    r.lo = p[W-1:0];
    r.hi = p[2*W-1:W];
    r.zf = (p == '0);
    r.sf = p[2*W-1];
    r.cf = s ? (r.hi != {W{r.lo[W-1]}}) : (r.hi != '0);
    return r;
  endfunction

  // Transaction model: an accepted request occupies W run cycles, one done
  // cycle, then one idle cycle before the next request can be taken.
  always @(negedge clk or negedge rst) begin
    if (!rst) m_rem = 0;
    else if (m_rem > 0) m_rem--;
    else if (start) begin
      exp_q.push_back(model(a, b, is_signed));
      m_rem = W + 1;
    end
  end

  // Monitor: handshake timing, scoreboard pop on done, held outputs otherwise.
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      hold_exp = '0;
    end
    chk("busy", busy, m_rem >= 2);
    chk("done", done, m_rem == 1);
    chk("busy_and_done", busy & done, 0);
    if (done) begin
      n_done++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at t=%0t", $time);
      end else hold_exp = exp_q.pop_front();
    end
    chk("product_lo", product_lo, hold_exp.lo);
    chk("product_hi", product_hi, hold_exp.hi);
    chk("zero_flag", zero_flag, hold_exp.zf);
    chk("sign_flag", sign_flag, hold_exp.sf);
    chk("carry_flag", carry_flag, hold_exp.cf);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_rem != 0 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit noise);
    wait_idle();
    start = 1'b1; a = x; b = y; is_signed = s;
    step();
    for (int i = 0; i < W + 1; i++) begin
      if (noise) begin
        start = ($urandom & 1) != 0;
        a = $urandom;
        b = $urandom;
        is_signed = ($urandom & 1) != 0;
      end else start = 1'b0;
      step();
    end
    start = 1'b0;
    wait_idle();
  endtask

  task automatic check_zero_now(input string tag);
    chk({tag, "_lo"}, product_lo, 0);
    chk({tag, "_hi"}, product_hi, 0);
    chk({tag, "_flags"}, {zero_flag, sign_flag, carry_flag}, 0);
    chk({tag, "_busy_done"}, {busy, done}, 0);
  endtask

  logic [W-1:0] edge_vals [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  initial begin
    int n0;
    logic [W-1:0] x, y;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_zero_now("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    run_op(32'd7, 32'd6, 1'b0, 1'b0);
    chk("u7x6_lo", product_lo, 64'h2A);
    chk("u7x6_hi", product_hi, 0);
    run_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
    chk("sm3x5_lo", product_lo, 64'hFFFFFFF1);
    chk("sm3x5_hi", product_hi, 64'hFFFFFFFF);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    chk("umax_hi", product_hi, 64'hFFFFFFFE);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1);
    chk("smin_hi", product_hi, 64'h40000000);
    run_op(32'h0, 32'h12345678, 1'b0, 1'b0);
    run_op(32'h0, 32'h12345678, 1'b1, 1'b1);
    chk("zero_zf", zero_flag, 1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op(32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);

    for (int i = 0; i < 25; i++) begin
      x = ($urandom_range(3, 0) == 0) ? edge_vals[$urandom_range(3, 0)] : $urandom;
      y = ($urandom_range(3, 0) == 0) ? edge_vals[$urandom_range(3, 0)] : $urandom;
      run_op(x, y, ($urandom & 1) != 0, ($urandom & 1) != 0);
    end

    wait_idle();
    n0 = n_done;
    for (int i = 0; i < 4 * (W + 2); i++) begin
      start = 1'b1;
      a = $urandom;
      b = $urandom;
      is_signed = ($urandom & 1) != 0;
      step();
    end
    start = 1'b0;
    wait_idle();
    chk("b2b_result_count", n_done - n0, 4);

    start = 1'b1; a = 32'd7; b = 32'd6; is_signed = 1'b0;
    step();
    start = 1'b0;
    repeat (10) step();
    rst = 1'b0;
    #1 check_zero_now("abort");
    step();
    step();
    rst = 1'b1;
    run_op(32'd7, 32'd6, 1'b0, 1'b0);
    chk("post_rst_lo", product_lo, 64'h2A);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at t=%0t expected finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (even, >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the negative edge of clk, matching the ALU flag register timing.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply, sampled on the clk negedge.
REQ-005 SHALL have port is_signed  input  1  1 selects two's-complement operands; 0 selects unsigned; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  multiplicand, sampled with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier, sampled with start.
REQ-008 SHALL have port busy  output  1  high while iterating.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking the cycle in which a new result is first valid.
REQ-010 SHALL have port product_lo  output  WIDTH  low half of the 2*WIDTH product.
REQ-011 SHALL have port product_hi  output  WIDTH  high half of the 2*WIDTH product.
REQ-012 SHALL have port zero_flag  output  1  full 2*WIDTH product equals 0.
REQ-013 SHALL have port sign_flag  output  1  MSB of product_hi.
REQ-014 SHALL have port carry_flag  output  1  result does not fit in WIDTH bits; consumed by the ALU flag flip-flops.

Function
REQ-015 SHALL implement three states: IDLE, RUN, DONE.
REQ-016 IDLE: on a negedge with start=1, SHALL latch a, b, is_signed, clear the accumulator and iteration counter, and enter RUN; start=0 stays in IDLE.
REQ-017 Signed mode SHALL latch operand magnitudes and record result sign = a[MSB] XOR b[MSB]; unsigned mode SHALL use the operands as-is.
REQ-018 RUN: each negedge SHALL perform one radix-2 shift-add step (add the multiplicand to the upper accumulator when the current multiplier LSB is 1, then shift right one bit with carry-in), exactly WIDTH steps.
REQ-019 On the negedge completing step WIDTH, SHALL apply two's-complement negation of the 2*WIDTH result when the recorded sign is 1, write product_hi/product_lo and all flags, and enter DONE.
REQ-020 DONE: SHALL assert done for exactly one cycle, then return to IDLE on the next negedge.
REQ-021 Latency: the result SHALL be valid, with done=1, WIDTH+1 negedges after the accepting edge, counting the accepting edge as the first.
REQ-022 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; they SHALL never both be 1.
REQ-023 start SHALL be ignored in RUN and DONE; no queuing, and the latched operands SHALL be unaffected.
REQ-024 product_hi, product_lo and the flags SHALL hold their last values during RUN and IDLE; they change only on entry to DONE.
REQ-025 carry_flag SHALL be: unsigned, product_hi != 0; signed, product_hi != sign-extension of product_lo[MSB].
REQ-026 Signed most-negative operands (e.g. 0x80000000 x 0x80000000 at WIDTH=32) SHALL produce the exact 2*WIDTH result with no internal overflow; the accumulator SHALL be WIDTH+1 bits.

Reset
REQ-027 rst=0 SHALL immediately force the state to IDLE and set busy, done, product_hi, product_lo, zero_flag, sign_flag and carry_flag to 0, independent of clk.
REQ-028 Reset during RUN or DONE SHALL abort the operation without producing a done pulse.
REQ-029 After rst returns to 1, the first negedge with start=1 SHALL be accepted normally.

Verification (WIDTH=32)
REQ-030 Unsigned 7 x 6 -> done after 33 edges; product_lo=0x0000002A, product_hi=0, zero_flag=0, sign_flag=0, carry_flag=0.
REQ-031 Signed -3 (0xFFFFFFFD) x 5 -> product_lo=0xFFFFFFF1, product_hi=0xFFFFFFFF, sign_flag=1, carry_flag=0.
REQ-032 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001, carry_flag=1; signed 0x80000000 x 0x80000000 -> product_hi=0x40000000, product_lo=0, carry_flag=1, sign_flag=0.
REQ-033 Zero operand: 0 x 0x12345678, either mode -> zero_flag=1, both halves 0, carry_flag=0.
REQ-034 Hold start=1 continuously with new operands on every edge -> exactly one result per 34 edges; operands presented during RUN and DONE are ignored; done never coincides with busy.
REQ-035 Assert rst=0 after the 10th RUN step -> outputs 0 at once with no done pulse; a subsequent 7 x 6 returns 42 with correct latency.
